// File: rtl/mem_arbiter_n.sv
// mem_arbiter_n: N-port main-memory arbiter.
// Serialises read/write commands (plus multi-beat write data) from NUM_PORTS
// clients onto one memory channel behind a registered grant, and routes
// response valids back to the client named by the response tag.
// Optional feature macro: MEM_ARB_RR_EN selects round-robin arbitration;
// when undefined, the lowest-indexed valid port always wins.

`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 32
`endif
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 64
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 4
`endif

module mem_arbiter_n #(
    parameter int NUM_PORTS   = 2,
    parameter int ADDR_BITS   = `MEM_ADDR_BITS,
    parameter int DATA_BITS   = `MEM_DATA_BITS,
    parameter int TAG_BITS    = `MEM_TAG_BITS,
    parameter int WRITE_BEATS = 4
) (
    input  logic                             clk,
    input  logic                             reset,

    input  logic [NUM_PORTS-1:0]             port_req_valid,
    output logic [NUM_PORTS-1:0]             port_req_ready,
    input  logic [NUM_PORTS-1:0]             port_req_rw,
    input  logic [NUM_PORTS*ADDR_BITS-1:0]   port_req_addr,
    input  logic [NUM_PORTS-1:0]             port_req_data_valid,
    output logic [NUM_PORTS-1:0]             port_req_data_ready,
    input  logic [NUM_PORTS*DATA_BITS-1:0]   port_req_data_bits,
    input  logic [NUM_PORTS*DATA_BITS/8-1:0] port_req_data_mask,
    output logic [NUM_PORTS-1:0]             port_resp_valid,

    output logic                             mem_req_valid,
    output logic                             mem_req_rw,
    input  logic                             mem_req_ready,
    output logic [ADDR_BITS-1:0]             mem_req_addr,
    output logic [TAG_BITS-1:0]              mem_req_tag,
    output logic                             mem_req_data_valid,
    input  logic                             mem_req_data_ready,
    output logic [DATA_BITS-1:0]             mem_req_data_bits,
    output logic [DATA_BITS/8-1:0]           mem_req_data_mask,
    input  logic                             mem_resp_valid,
    input  logic [TAG_BITS-1:0]              mem_resp_tag
);

    localparam int IDX_BITS  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNT_BITS  = (WRITE_BEATS > 1) ? $clog2(WRITE_BEATS + 1) : 1;
    localparam int MASK_BITS = DATA_BITS / 8;

    localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(WRITE_BEATS - 1);
    localparam logic [IDX_BITS-1:0] LAST_PORT = IDX_BITS'(NUM_PORTS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WDATA = 2'd2
    } state_e;

    state_e                state_q,  state_d;
    logic [IDX_BITS-1:0]   grant_q,  grant_d;
    logic [IDX_BITS-1:0]   prio_q,   prio_d;
    logic [CNT_BITS-1:0]   cnt_q,    cnt_d;

    logic [IDX_BITS-1:0]   winner;
    logic                  winner_found;
    logic [IDX_BITS-1:0]   prio_next;
    logic [NUM_PORTS-1:0]  grant_oh;

    logic                  sel_valid;
    logic                  sel_rw;
    logic [ADDR_BITS-1:0]  sel_addr;
    logic                  sel_data_valid;
    logic [DATA_BITS-1:0]  sel_data_bits;
    logic [MASK_BITS-1:0]  sel_data_mask;

    logic                  cmd_fire;
    logic                  beat_fire;

    // Pick the first valid port at or above the priority pointer, wrapping
    // at the top. With the pointer pinned at 0 this is plain fixed priority.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        winner       = prio_q;
        winner_found = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!winner_found && port_req_valid[(int'(prio_q) + k) % NUM_PORTS]) begin
                winner       = IDX_BITS'((int'(prio_q) + k) % NUM_PORTS);
                winner_found = 1'b1;
            end
        end
    end

    // Steer the granted port's command and write-beat fields onto local buses.
    always_comb begin
        grant_oh       = '0;
        sel_valid      = 1'b0;
        sel_rw         = 1'b0;
        sel_addr       = '0;
        sel_data_valid = 1'b0;
        sel_data_bits  = '0;
        sel_data_mask  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_q == IDX_BITS'(i)) begin
                grant_oh[i]    = 1'b1;
                sel_valid      = port_req_valid[i];
                sel_rw         = port_req_rw[i];
                sel_addr       = port_req_addr[i*ADDR_BITS +: ADDR_BITS];
                sel_data_valid = port_req_data_valid[i];
                sel_data_bits  = port_req_data_bits[i*DATA_BITS +: DATA_BITS];
                sel_data_mask  = port_req_data_mask[i*MASK_BITS +: MASK_BITS];
            end
        end
    end

    assign cmd_fire  = (state_q == REQ)   && sel_valid      && mem_req_ready;
    assign beat_fire = (state_q == WDATA) && sel_data_valid && mem_req_data_ready;

`ifdef MEM_ARB_RR_EN
    // Round-robin: the port after the one just served gets first look next.
    assign prio_next = (grant_q == LAST_PORT) ? '0 : grant_q + IDX_BITS'(1);
`else
    // Fixed priority: the scan always starts at port 0.
    assign prio_next = '0;
`endif

    // Next-state logic for the grant/write-data sequencer.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (winner_found) begin
                    grant_d = winner;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (!sel_valid) begin
                    // Client withdrew its command: re-arbitrate without issuing.
                    state_d = IDLE;
                end else if (cmd_fire) begin
                    prio_d = prio_next;
                    if (sel_rw) begin
                        cnt_d   = '0;
                        state_d = WDATA;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            WDATA: begin
                if (beat_fire) begin
                    cnt_d = cnt_q + CNT_BITS'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer registers; reset abandons any in-flight write.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            prio_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
        end
    end

    // Memory-side and port-side handshake outputs, decoded from the state.
    always_comb begin
        mem_req_valid       = 1'b0;
        mem_req_rw          = 1'b0;
        mem_req_addr        = sel_addr;
        mem_req_tag         = TAG_BITS'(grant_q);
        mem_req_data_valid  = 1'b0;
        mem_req_data_bits   = sel_data_bits;
        mem_req_data_mask   = sel_data_mask;
        port_req_ready      = '0;
        port_req_data_ready = '0;
        case (state_q)
            REQ: begin
                mem_req_valid  = sel_valid;
                mem_req_rw     = sel_rw;
                port_req_ready = grant_oh & {NUM_PORTS{mem_req_ready}};
            end
            WDATA: begin
                mem_req_data_valid  = sel_data_valid;
                port_req_data_ready = grant_oh & {NUM_PORTS{mem_req_data_ready}};
            end
            default: begin
            end
        endcase
    end

    // Response steering by tag; out-of-range tags match no port.
    always_comb begin
        port_resp_valid = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            port_resp_valid[i] = !reset && mem_resp_valid &&
                                 (mem_resp_tag == TAG_BITS'(i));
        end
    end

endmodule

// File: doc/mem_arbiter_n.md
# mem_arbiter_n

Parametrised N-port main-memory arbiter; successor of the fixed two-port icache/dcache arbiter. It sits between NUM_PORTS cache or DMA clients and the single main-memory request/write-data/response channel. It serialises commands, including multi-beat write data, behind a registered grant. Responses are routed back by tag. Response data is broadcast to all clients outside this block; only per-port response valids are generated here.

## Interface
- NUM_PORTS, 2: client count, 1..8
- ADDR_BITS, `MEM_ADDR_BITS: memory address width
- DATA_BITS, `MEM_DATA_BITS: memory data beat width
- TAG_BITS, `MEM_TAG_BITS: tag width; must be >= IDX_BITS = max(1, clog2(NUM_PORTS))
- WRITE_BEATS, 4: data beats per write command, >= 1

Ports:
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-high
- port_req_valid  in  NUM_PORTS  per-port command valid
- port_req_ready  out  NUM_PORTS  per-port command accept
- port_req_rw  in  NUM_PORTS  1 = write, 0 = read
- port_req_addr  in  NUM_PORTS*ADDR_BITS  port i at [i*ADDR_BITS +: ADDR_BITS]
- port_req_data_valid  in  NUM_PORTS  write beat valid
- port_req_data_ready  out  NUM_PORTS  write beat accept
- port_req_data_bits  in  NUM_PORTS*DATA_BITS  write beat data
- port_req_data_mask  in  NUM_PORTS*DATA_BITS/8  byte mask
- port_resp_valid  out  NUM_PORTS  read response for port i
- mem_req_valid, mem_req_rw  out  1; mem_req_ready  in  1
- mem_req_addr  out  ADDR_BITS; mem_req_tag  out  TAG_BITS
- mem_req_data_valid  out  1; mem_req_data_ready  in  1
- mem_req_data_bits  out  DATA_BITS; mem_req_data_mask  out  DATA_BITS/8
- mem_resp_valid  in  1; mem_resp_tag  in  TAG_BITS

## Operation
- FSM states: IDLE, REQ, WDATA. Registers: grant index g (IDX_BITS), priority pointer p, beat counter (clog2(WRITE_BEATS+1) bits).
- IDLE: if any port_req_valid is high, latch winner into g and go to REQ. Otherwise stay.
- REQ: mem_req_valid = port_req_valid[g]; rw, addr from port g; mem_req_tag = g zero-extended. port_req_ready[g] = mem_req_ready; all other ports' ready = 0.
  - Handshake with rw=0: go to IDLE.
  - Handshake with rw=1: clear counter, go to WDATA.
  - port_req_valid[g] low: go to IDLE (re-arbitrate), no command issued.
- WDATA: mem_req_data_valid/bits/mask come from port g; port_req_data_ready[g] = mem_req_data_ready. Each valid&ready beat increments the counter; the beat that brings it to WRITE_BEATS returns to IDLE. No new command is issued during WDATA.
- Response path is independent of the FSM: port_resp_valid[i] = mem_resp_valid & (mem_resp_tag == i). Tags >= NUM_PORTS are dropped, so no port valid is raised.
- Outputs not selected in the current state are 0. Data/addr buses may carry don't-care values when their valid is low.

## Timing
- Reset, asynchronous: state IDLE, g=0, p=0, counter 0. mem_req_valid, mem_req_data_valid, all port ready and resp_valid outputs 0 immediately.
- Reset mid-write drops the transaction; the memory model is reset in the same cycle.
- Latency: port valid in cycle n gives mem_req_valid in cycle n+1 at earliest. IDLE always costs one cycle between commands.
- Read throughput is at most one command per 2 cycles. A write occupies at least 2+WRITE_BEATS cycles.
- Responses are combinational, 0-cycle. A response in the same cycle as any request or data handshake is handled concurrently.
- Ports must hold addr/rw/data stable while valid and not ready.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration. The winner is the first valid port at or after p, scanning upward with wrap at NUM_PORTS-1 -> 0. On command handshake, p <= g+1, wrapping to 0 after NUM_PORTS-1.
- MEM_ARB_RR_EN undefined: fixed priority, lowest valid index wins; p is unused and held at 0.

## Test plan
- Reset mid-WDATA, after beat 2 of 4 -> all valids/readies 0 asynchronously, FSM IDLE. Next port0 read issues cleanly with tag 0.
- Ports 0 and 1 both post reads continuously, mem_req_ready=1 -> with MEM_ARB_RR_EN, tags alternate 0,1,0,1 one command per 2 cycles. Without it, all tags are 0.
- Port1 write, WRITE_BEATS=4, data_ready toggling 1,0,1,1,0,1 -> exactly 4 beats forwarded in order with masks intact. Port0 read is held off until return to IDLE.
- mem_resp_valid with tag 1, then tag 5 with NUM_PORTS=2 -> port_resp_valid=2'b10, then 2'b00.
- NUM_PORTS=4, all valid, RR -> grant order 0,1,2,3,0. With port2 deasserting in REQ, the FSM returns to IDLE and no command with tag 2 is issued.
- Response arriving in the same cycle as a port0 command handshake -> both complete correctly in that cycle.
